// File: rtl/hazard_ctrl.sv
// Stall/forward controller for a 5-stage MIPS pipeline.
// Keeps a shadow copy of the E/M/W destination records and applies Tuse/Tnew
// rules to produce the D-stage stall and the per-operand forward selects.
// Also owns the mult/div busy countdown that holds off HI/LO users.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic [4:0] dst_D,
  input  logic       regwrite_D,
  input  logic [1:0] tnew_D,
  input  logic       md_start_D,
  input  logic       md_div_D,
  input  logic       md_use_D,
  output logic       stall,
  output logic       md_busy,
  output logic [1:0] fwd_rs_D,
  output logic [1:0] fwd_rt_D,
  output logic [1:0] fwd_rs_E,
  output logic [1:0] fwd_rt_E,
  output logic       fwd_rt_M
);

  // E record carries everything later stages or the counter still need.
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic       we;
    logic [1:0] tnew;
    logic       md_start;
    logic       md_div;
  } e_rec_t;

  e_rec_t           e_q;
  e_rec_t           e_d;
  logic [4:0]       m_rt;
  logic [4:0]       m_dst;
  logic             m_we;
  logic [1:0]       m_tnew;
  logic [4:0]       w_dst;
  logic             w_we;
  logic [CNT_W-1:0] cnt;
  logic             stall_raw;
  logic             rs_stall;
  logic             rt_stall;
  logic             md_stall;

  // Producer X supplies operand r; R0 is never a real dependency.
  function automatic logic hit(input logic we, input logic [4:0] dst,
                               input logic [4:0] r);
    return we && (dst == r) && (r != 5'd0);
  endfunction

  // D-stage source: check the nearest stage first. An older value picked here
  // while a younger producer is still computing is replaced by E forwarding.
  function automatic logic [1:0] sel_d(input logic [4:0] r);
    if (hit(e_q.we, e_q.dst, r) && e_q.tnew == 2'd0) return 2'd1;
    if (hit(m_we, m_dst, r) && m_tnew == 2'd0)       return 2'd2;
    if (hit(w_we, w_dst, r))                         return 2'd3;
    return 2'd0;
  endfunction

  // E-stage source: M result if ready, else W write data.
  function automatic logic [1:0] sel_e(input logic [4:0] r);
    if (hit(m_we, m_dst, r) && m_tnew == 2'd0) return 2'd2;
    if (hit(w_we, w_dst, r))                   return 2'd3;
    return 2'd0;
  endfunction

  // Pack the D-stage instruction into the record that enters E.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    e_d          = '0;
    e_d.rs       = rs_D;
    e_d.rt       = rt_D;
    e_d.dst      = dst_D;
    e_d.we       = regwrite_D && (dst_D != 5'd0);
    e_d.tnew     = tnew_D;
    e_d.md_start = md_start_D;
    e_d.md_div   = md_start_D && md_div_D;
  end

  // Stall when a producer in E or M will not have its result by Tuse,
  // or when a HI/LO user meets a running or just-issued mult/div.
  always_comb begin
    rs_stall  = (hit(e_q.we, e_q.dst, rs_D) && (e_q.tnew > tuse_rs_D)) ||
                (hit(m_we, m_dst, rs_D) && (m_tnew > tuse_rs_D));
    rt_stall  = (hit(e_q.we, e_q.dst, rt_D) && (e_q.tnew > tuse_rt_D)) ||
                (hit(m_we, m_dst, rt_D) && (m_tnew > tuse_rt_D));
    md_stall  = md_use_D && ((cnt != '0) || e_q.md_start);
    stall_raw = rs_stall || rt_stall || md_stall;
  end

  // Outputs are held at zero for as long as reset is asserted.
  always_comb begin
    stall    = 1'b0;
    md_busy  = 1'b0;
    fwd_rs_D = 2'd0;
    fwd_rt_D = 2'd0;
    fwd_rs_E = 2'd0;
    fwd_rt_E = 2'd0;
    fwd_rt_M = 1'b0;
    if (!reset) begin
      stall    = stall_raw;
      md_busy  = (cnt != '0);
      fwd_rs_D = sel_d(rs_D);
      fwd_rt_D = sel_d(rt_D);
      fwd_rs_E = sel_e(e_q.rs);
      fwd_rt_E = sel_e(e_q.rt);
      fwd_rt_M = hit(w_we, w_dst, m_rt);
    end
  end

  // Shadow pipeline advances every cycle; a stall injects a bubble into E.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    if (reset) begin
      e_q    <= '0;
      m_rt   <= '0;
      m_dst  <= '0;
      m_we   <= 1'b0;
      m_tnew <= '0;
      w_dst  <= '0;
      w_we   <= 1'b0;
    end else begin
      w_dst  <= m_dst;
      w_we   <= m_we;
      m_rt   <= e_q.rt;
      m_dst  <= e_q.dst;
      m_we   <= e_q.we;
      m_tnew <= (e_q.tnew != 2'd0) ? e_q.tnew - 2'd1 : 2'd0;
      e_q    <= stall_raw ? '0 : e_d;
    end
  end

  // Busy countdown loads as the mult/div leaves E, then runs down to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (e_q.md_start) begin
      cnt <= e_q.md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule
